// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and helpers for the dual-edge FIFO controller.
// Optional peak tracking in the top is enabled by defining FIFO_CTRL_PEAK_TRACK_EN.
package fifo_ctrl_pkg;

    localparam int unsigned DEF_WIDTH     = 7;
    localparam int unsigned DEF_CNT_WIDTH = 8;

    // Occupancy of two (w+1)-bit pointers, modulo 2^(w+1).
    function automatic logic [31:0] occupancy(input logic [31:0] wr_ptr,
                                              input logic [31:0] rd_ptr,
                                              input int unsigned w);
        return (wr_ptr - rd_ptr) & ((32'd1 << (w + 1)) - 32'd1);
    endfunction

    // Largest value representable in w bits (saturation ceiling).
    function automatic logic [31:0] sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ddr_status_sat_counter.sv
// Saturating event counter with synchronous clear; clock edge selected by NEG_EDGE.
module sat_counter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned W        = DEF_CNT_WIDTH,
    parameter bit          NEG_EDGE = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = W'(sat_max(W));

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment, increment stops at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    generate
        if (NEG_EDGE) begin : g_neg
            // Count register on the falling edge (write domain).
            always_ff @(negedge clk) begin
                if (!reset) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end else begin : g_pos
            // Count register on the rising edge (read domain).
            always_ff @(posedge clk) begin
                if (!reset) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end
    endgenerate

    assign cnt = cnt_q;

endmodule

// File: rtl/fifo_ctrl_ddr_status.sv
// Dual-edge FIFO address/flag controller: writes on falling clk, reads on rising clk.
// Define FIFO_CTRL_PEAK_TRACK_EN to enable peak-occupancy tracking on peakCount.
module fifo_ctrl_ddr_status
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wren,
    input  logic                 rden,
    input  logic                 enWordCount,
    input  logic                 clrStatus,
    input  logic [WIDTH:0]       afThresh,
    output logic                 empty,
    output logic                 full,
    output logic                 almostFull,
    output logic [WIDTH-1:0]     wrAddr,
    output logic [WIDTH-1:0]     rdAddr,
    output logic [WIDTH:0]       wordCount,
    output logic [CNT_WIDTH-1:0] ovfCnt,
    output logic [CNT_WIDTH-1:0] udfCnt,
    output logic [WIDTH:0]       peakCount
);

    localparam int unsigned PTR_W = WIDTH + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] occ;

    // Flags and occupancy derived directly from the pointer registers.
    always_comb begin
        occ        = PTR_W'(occupancy(32'(wr_ptr_q), 32'(rd_ptr_q), WIDTH));
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[WIDTH] != rd_ptr_q[WIDTH]) &&
                     (wr_ptr_q[WIDTH-1:0] == rd_ptr_q[WIDTH-1:0]);
        almostFull = (afThresh != '0) && (occ >= afThresh);
        wordCount  = enWordCount ? occ : '0;
    end

    assign wrAddr = wr_ptr_q[WIDTH-1:0];
    assign rdAddr = rd_ptr_q[WIDTH-1:0];

    // Pointer advance: each side moves only when the FIFO permits it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wren && !full)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rden && !empty) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Write pointer lives in the falling-edge domain.
    always_ff @(negedge clk) begin
        if (!reset) wr_ptr_q <= '0;
        else        wr_ptr_q <= wr_ptr_d;
    end

    // Read pointer lives in the rising-edge domain.
    always_ff @(posedge clk) begin
        if (!reset) rd_ptr_q <= '0;
        else        rd_ptr_q <= rd_ptr_d;
    end

    // Dropped writes, counted in the write domain.
    sat_counter #(.W(CNT_WIDTH), .NEG_EDGE(1'b1)) u_ovf (
        .clk   (clk),
        .reset (reset),
        .inc   (wren && full),
        .clr   (clrStatus),
        .cnt   (ovfCnt)
    );

    // Ignored reads, counted in the read domain.
    sat_counter #(.W(CNT_WIDTH), .NEG_EDGE(1'b0)) u_udf (
        .clk   (clk),
        .reset (reset),
        .inc   (rden && empty),
        .clr   (clrStatus),
        .cnt   (udfCnt)
    );

`ifdef FIFO_CTRL_PEAK_TRACK_EN
    logic [PTR_W-1:0] peak_q, peak_d;

    // Peak follows the occupancy seen just before each rising edge.
    always_comb begin
        peak_d = peak_q;
        if (clrStatus)          peak_d = '0;
        else if (occ > peak_q)  peak_d = occ;
    end

    // Peak register in the rising-edge domain.
    always_ff @(posedge clk) begin
        if (!reset) peak_q <= '0;
        else        peak_q <= peak_d;
    end

    assign peakCount = peak_q;
`else
    assign peakCount = '0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_ddr_status.sv
// Directed self-checking bench for fifo_ctrl_ddr_status (WIDTH=3, CNT_WIDTH=4).
module tb_fifo_ctrl_ddr_status;

    localparam int unsigned WIDTH     = 3;
    localparam int unsigned CNT_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 wren;
    logic                 rden;
    logic                 enWordCount;
    logic                 clrStatus;
    logic [WIDTH:0]       afThresh;
    logic                 empty;
    logic                 full;
    logic                 almostFull;
    logic [WIDTH-1:0]     wrAddr;
    logic [WIDTH-1:0]     rdAddr;
    logic [WIDTH:0]       wordCount;
    logic [CNT_WIDTH-1:0] ovfCnt;
    logic [CNT_WIDTH-1:0] udfCnt;
    logic [WIDTH:0]       peakCount;

    int checks   = 0;
    int failures = 0;

`ifdef FIFO_CTRL_PEAK_TRACK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    fifo_ctrl_ddr_status #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .wren        (wren),
        .rden        (rden),
        .enWordCount (enWordCount),
        .clrStatus   (clrStatus),
        .afThresh    (afThresh),
        .empty       (empty),
        .full        (full),
        .almostFull  (almostFull),
        .wrAddr      (wrAddr),
        .rdAddr      (rdAddr),
        .wordCount   (wordCount),
        .ovfCnt      (ovfCnt),
        .udfCnt      (udfCnt),
        .peakCount   (peakCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic neg_step();
        @(negedge clk);
        #1;
    endtask

    task automatic pos_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string ph);
        chk({ph, "_empty"},     32'(empty),      32'd1);
        chk({ph, "_full"},      32'(full),       32'd0);
        chk({ph, "_af"},        32'(almostFull), 32'd0);
        chk({ph, "_wrAddr"},    32'(wrAddr),     32'd0);
        chk({ph, "_rdAddr"},    32'(rdAddr),     32'd0);
        chk({ph, "_wordCount"}, 32'(wordCount),  32'd0);
        chk({ph, "_ovfCnt"},    32'(ovfCnt),     32'd0);
        chk({ph, "_udfCnt"},    32'(udfCnt),     32'd0);
        chk({ph, "_peak"},      32'(peakCount),  32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        wren        = 1'b0;
        rden        = 1'b0;
        enWordCount = 1'b1;
        clrStatus   = 1'b0;
        afThresh    = 4'd6;

        // Reset held for two full cycles.
        neg_step(); pos_step(); neg_step(); pos_step();
        chk_reset_state("rst0");
        reset = 1'b1;

        // Fill with 8 writes.
        wren = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            neg_step();
            chk($sformatf("fill_wc%0d", i), 32'(wordCount),  32'(i));
            chk($sformatf("fill_af%0d", i), 32'(almostFull), 32'(i >= 6));
            chk($sformatf("fill_fu%0d", i), 32'(full),       32'(i == 8));
        end
        chk("fill_wrAddr", 32'(wrAddr), 32'd0);
        chk("fill_empty",  32'(empty),  32'd0);

        // Threshold boundaries while full.
        afThresh = 4'd0; #1;
        chk("af_thr0", 32'(almostFull), 32'd0);
        afThresh = 4'd9; #1;
        chk("af_thr9", 32'(almostFull), 32'd0);
        afThresh = 4'd8; #1;
        chk("af_thr8", 32'(almostFull), 32'd1);
        afThresh = 4'd6;

        // Writes into a full FIFO: pointer holds, ovf counts then saturates.
        for (int k = 1; k <= 3; k++) begin
            neg_step();
            chk($sformatf("ovf_cnt%0d", k), 32'(ovfCnt), 32'(k));
            chk($sformatf("ovf_wra%0d", k), 32'(wrAddr), 32'd0);
        end
        repeat (20) neg_step();
        chk("ovf_sat",   32'(ovfCnt),    32'd15);
        chk("ovf_wc",    32'(wordCount), 32'd8);

        // Drain 8, then 2 extra reads.
        wren = 1'b0;
        rden = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            pos_step();
            chk($sformatf("drain_wc%0d", i), 32'(wordCount), 32'(8 - i));
        end
        chk("drain_empty",  32'(empty),  32'd1);
        chk("drain_rdAddr", 32'(rdAddr), 32'd0);
        for (int k = 1; k <= 2; k++) begin
            pos_step();
            chk($sformatf("udf_cnt%0d", k), 32'(udfCnt), 32'(k));
            chk($sformatf("udf_rda%0d", k), 32'(rdAddr), 32'd0);
        end
        rden = 1'b0;

        // Continuous write+read for 40 cycles.
        wren = 1'b1;
        rden = 1'b1;
        for (int i = 0; i < 40; i++) begin
            neg_step();
            chk("stream_wc_neg", 32'(wordCount), 32'd1);
            chk("stream_full",   32'(full),      32'd0);
            pos_step();
            chk("stream_wc_pos", 32'(wordCount), 32'd0);
        end
        wren = 1'b0;
        rden = 1'b0;
        chk("stream_wrAddr", 32'(wrAddr), 32'd0);
        chk("stream_rdAddr", 32'(rdAddr), 32'd0);
        chk("stream_ovf",    32'(ovfCnt), 32'd15);
        chk("stream_udf",    32'(udfCnt), 32'd2);

        // Clear with a competing underflow read: clear wins.
        clrStatus = 1'b1;
        rden      = 1'b1;
        neg_step();
        chk("clr_ovf", 32'(ovfCnt), 32'd0);
        pos_step();
        chk("clr_udf",  32'(udfCnt),    32'd0);
        chk("clr_peak", 32'(peakCount), 32'd0);
        clrStatus = 1'b0;
        rden      = 1'b0;

        // Fill to 5, drain to 2.
        wren = 1'b1;
        repeat (5) neg_step();
        wren = 1'b0;
        rden = 1'b1;
        repeat (3) pos_step();
        rden = 1'b0;
        chk("pk_wc2",  32'(wordCount), 32'd2);
        chk("pk_pre",  32'(peakCount), PEAK_ON ? 32'd5 : 32'd0);
        clrStatus = 1'b1;
        neg_step(); pos_step();
        chk("pk_clr",  32'(peakCount), 32'd0);
        clrStatus = 1'b0;
        wren = 1'b1;
        neg_step();
        wren = 1'b0;
        pos_step();
        chk("pk_wc3",  32'(wordCount), 32'd3);
        chk("pk_end",  32'(peakCount), PEAK_ON ? 32'd3 : 32'd0);

        // Build ovfCnt=2 with 4 words stored.
        wren = 1'b1;
        repeat (7) neg_step();
        wren = 1'b0;
        chk("mid_full", 32'(full),   32'd1);
        chk("mid_ovf",  32'(ovfCnt), 32'd2);
        rden = 1'b1;
        repeat (4) pos_step();
        rden = 1'b0;
        chk("mid_wc4",   32'(wordCount), 32'd4);
        chk("mid_empty", 32'(empty),     32'd0);

        // Word count gated off; flags unaffected.
        enWordCount = 1'b0; #1;
        chk("wcoff_wc",    32'(wordCount), 32'd0);
        chk("wcoff_empty", 32'(empty),     32'd0);
        enWordCount = 1'b1; #1;
        chk("wcon_wc",     32'(wordCount), 32'd4);

        // Mid-stream reset discards everything.
        reset = 1'b0;
        neg_step(); pos_step();
        chk_reset_state("rst1");
        reset = 1'b1;

        // Operation resumes from address 0.
        wren = 1'b1;
        neg_step();
        wren = 1'b0;
        chk("post_wc",     32'(wordCount), 32'd1);
        chk("post_wrAddr", 32'(wrAddr),    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
